// File: rtl/tlp_rxpd_pktfifo.sv
// tlp_rxpd_pktfifo: store-and-forward packet FIFO for received posted-data TLP beats.
// Beats are written speculatively and become readable only when the packet's
// last beat commits. Errored packets roll back; packets larger than the RAM are
// dropped in flight so RX never deadlocks behind an unfinishable packet.
module tlp_rxpd_pktfifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_keep,
  input  logic                wr_last,
  input  logic                wr_err,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W/8-1:0] rd_keep,
  output logic                rd_last,
  output logic [ADDR_W:0]     pkt_cnt,
  output logic [ADDR_W:0]     free_cnt,
  output logic [15:0]         drop_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ENT_W  = 1 + KEEP_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t state, state_nx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] wr_cmt;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] used;
  logic [ADDR_W:0] spec_len;

  logic full;
  logic oversize;
  logic wr_rdy_c;
  logic wr_acc;
  logic ram_we;
  logic commit;
  logic rollback;
  logic drop_inc;

  logic adv;
  logic rd_en;
  logic rd_hs_last;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ram_p0;
  logic             vld_p0;

  assign used     = wr_ptr - rd_ptr;
  assign spec_len = wr_ptr - wr_cmt;
  assign full     = (used == DEPTH_P);
  assign free_cnt = DEPTH_P - used;

  // Write-side FSM: next state, write-ready and oversize detection
  always_comb begin
    state_nx = state;
    wr_rdy_c = 1'b0;
    oversize = 1'b0;
    case (state)
      PASS: begin
        wr_rdy_c = !full;
        // RAM is full of one uncommitted packet: it can never complete, so drop it.
        if (full && (spec_len == DEPTH_P)) begin
          oversize = 1'b1;
          state_nx = DROP;
        end
      end
      DROP: begin
        wr_rdy_c = 1'b1;
        if (wr_valid && wr_last && !rst) begin
          state_nx = PASS;
        end
      end
    endcase
  end

  // wr_ready is held low for the whole time reset is asserted.
  assign wr_ready = wr_rdy_c & ~rst;
  assign wr_acc   = wr_valid & wr_ready;
  assign ram_we   = wr_acc & (state == PASS);
  assign commit   = ram_we & wr_last & ~wr_err;
  assign rollback = ram_we & wr_last & wr_err;
  assign drop_inc = rollback | (wr_acc & wr_last & (state == DROP));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PASS;
    end else begin
      state <= state_nx;
    end
  end

  // Speculative and committed write pointers; rollback rewinds to last commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      wr_cmt <= '0;
    end else begin
      if (oversize || rollback) begin
        wr_ptr <= wr_cmt;
      end else if (ram_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        wr_cmt <= wr_ptr + 1'b1;
      end
    end
  end

  // Drop counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_inc) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Read side: stage p0 is the RAM read register, then the output register.
  // The pipeline only advances when the output slot is empty or being consumed.
  assign adv        = ~rd_valid | rd_ready;
  assign rd_en      = (rd_ptr != wr_cmt) & (~vld_p0 | adv);
  assign rd_hs_last = rd_valid & rd_ready & rd_last;

  // Storage RAM write port and registered read port (p0 data)
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_keep, wr_data};
    end
    if (rd_en) begin
      ram_p0 <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  // Read pointer and p0 valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        vld_p0 <= 1'b1;
      end else if (adv) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Output register: loads from p0 when advancing, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_keep  <= '0;
      rd_data  <= '0;
    end else if (adv) begin
      rd_valid <= vld_p0;
      if (vld_p0) begin
        {rd_last, rd_keep, rd_data} <= ram_p0;
      end
    end
  end

  // Committed packet count: +1 on commit, -1 on last-beat handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, rd_hs_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_rxpd_pktfifo.sv
// Testbench for tlp_rxpd_pktfifo: directed packets, expected beats queued at
// issue time, separate monitor pops and compares on every read handshake.
module tb_tlp_rxpd_pktfifo;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int KEEP_W = 8;
  localparam int DEPTH  = 16;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic [KEEP_W-1:0] wr_keep = '0;
  logic              wr_last = 1'b0;
  logic              wr_err = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [KEEP_W-1:0] rd_keep;
  logic              rd_last;
  logic [ADDR_W:0]   pkt_cnt;
  logic [ADDR_W:0]   free_cnt;
  logic [15:0]       drop_cnt;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_pkt = 0;
  int    pk_peak = 0;
  logic  good_flag = 1'b0;
  logic  stall_seen = 1'b0;
  beat_t stall_beat;
  logic  t5_done = 1'b0;

  tlp_rxpd_pktfifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_keep(wr_keep),
    .wr_last(wr_last), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_keep(rd_keep),
    .rd_last(rd_last), .pkt_cnt(pkt_cnt), .free_cnt(free_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk_beat(input int id, input int i, input int len);
    beat_t b;
    b.data = {id[31:0], i[31:0]};
    b.last = (i == len - 1);
    b.keep = b.last ? 8'h0F : 8'hFF;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, per-cycle pkt_cnt/free_cnt consistency
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (rst) begin
      m_pkt = 0;
      stall_seen = 1'b0;
    end else begin
      got = {rd_last, rd_keep, rd_data};
      checks++;
      if (int'(pkt_cnt) != m_pkt) begin
        errors++;
        $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, m_pkt);
      end
      checks++;
      if (int'(free_cnt) > DEPTH) begin
        errors++;
        $display("FAIL free_cnt_range: got %0d expected <= %0d", free_cnt, DEPTH);
      end
      if (stall_seen) begin
        checks++;
        if (!rd_valid || got !== stall_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", rd_valid, got, stall_beat);
        end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rd_beat: got %h expected %h", got, e);
          end
        end
      end
      stall_seen = rd_valid && !rd_ready;
      stall_beat = got;
      if (wr_valid && wr_ready && wr_last && good_flag) m_pkt++;
      if (rd_valid && rd_ready && rd_last) m_pkt--;
      if (m_pkt > pk_peak) pk_peak = m_pkt;
    end
  end

  task automatic put_beat(input beat_t b, input logic err);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = b.data;
    wr_keep  = b.keep;
    wr_last  = b.last;
    wr_err   = err;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL wr_accept_timeout: got wr_ready=0 for %0d cycles expected accept", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int id, input int len, input logic err, input logic good);
    if (good) begin
      for (int i = 0; i < len; i++) exp_q.push_back(mk_beat(id, i, len));
    end
    good_flag = good;
    for (int i = 0; i < len; i++) put_beat(mk_beat(id, i, len), err && (i == len - 1));
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    wr_err    = 1'b0;
    good_flag = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 || pkt_cnt != 0) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL %s_drain: got %0d beats pending expected 0", name, exp_q.size());
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lens[8];
    lens = '{3, 1, 8, 5, 2, 7, 4, 6};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_keep", 64'(rd_keep), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_free_cnt", 64'(free_cnt), 64'd16);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1: three 4-beat packets, commit-to-valid latency
    rd_ready = 1'b1;
    pk_peak  = 0;
    send_pkt(1, 4, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_lat_n0", 64'(rd_valid), 64'd0);
    @(negedge clk);
    chk("t1_lat_n1", 64'(rd_valid), 64'd0);
    @(negedge clk);
    chk("t1_lat_n2", 64'(rd_valid), 64'd1);
    @(posedge clk);
    #1;
    send_pkt(2, 4, 1'b0, 1'b1);
    send_pkt(3, 4, 1'b0, 1'b1);
    drain("t1");
    chk("t1_pk_peak_ge1", 64'(pk_peak >= 1), 64'd1);
    chk("t1_pkt_cnt_end", 64'(pkt_cnt), 64'd0);

    // 2: errored packet rolled back, good packet follows
    send_pkt(10, 5, 1'b1, 1'b0);
    send_pkt(11, 2, 1'b0, 1'b1);
    drain("t2");
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2_free_cnt", 64'(free_cnt), 64'd16);

    // 3: exactly-full packet with reader stalled
    rd_ready = 1'b0;
    send_pkt(20, 16, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_wr_ready_full", 64'(wr_ready), 64'd0);
    chk("t3_free_cnt_full", 64'(free_cnt), 64'd0);
    @(posedge clk);
    #1;
    send_pkt(21, 1, 1'b0, 1'b1);
    rd_ready = 1'b1;
    drain("t3");
    chk("t3_free_cnt", 64'(free_cnt), 64'd16);

    // 4: oversize packet dropped in flight
    send_pkt(30, 20, 1'b0, 1'b0);
    drain("t4");
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_free_cnt", 64'(free_cnt), 64'd16);
    chk("t4_rd_valid", 64'(rd_valid), 64'd0);

    // 5: toggling reader, mixed lengths, one errored packet
    t5_done = 1'b0;
    fork
      begin
        while (!t5_done) begin
          @(posedge clk);
          #1;
          rd_ready = ~rd_ready;
        end
      end
      begin
        for (int i = 0; i < 8; i++) send_pkt(40 + i, lens[i], (i == 4), (i != 4));
        t5_done = 1'b1;
      end
    join
    rd_ready = 1'b1;
    drain("t5");
    chk("t5_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("t5_free_cnt", 64'(free_cnt), 64'd16);

    // 6: reset mid-packet with two committed packets held
    rd_ready = 1'b0;
    send_pkt(50, 3, 1'b0, 1'b1);
    send_pkt(51, 2, 1'b0, 1'b1);
    put_beat(mk_beat(52, 0, 4), 1'b0);
    put_beat(mk_beat(52, 1, 4), 1'b0);
    chk("t6_pre_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("t6_pre_rd_valid", 64'(rd_valid), 64'd1);
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_last = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_rd_data", rd_data, 64'd0);
    chk("t6_rd_keep", 64'(rd_keep), 64'd0);
    chk("t6_rd_last", 64'(rd_last), 64'd0);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t6_free_cnt", 64'(free_cnt), 64'd16);
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t6_wr_ready", 64'(wr_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_wr_ready_after", 64'(wr_ready), 64'd1);
    rd_ready = 1'b1;
    send_pkt(53, 3, 1'b0, 1'b1);
    drain("t6");
    chk("t6_drop_cnt_end", 64'(drop_cnt), 64'd0);
    chk("t6_free_cnt_end", 64'(free_cnt), 64'd16);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
